wb_merge: RTL and testbench

WB_MERGE -- requirements
Module: wb_merge

---
 rtl/wb_merge_pkg.sv | 24 ++
 rtl/wb_merge_if.sv | 42 ++++
 rtl/wb_merge_load_align.sv | 39 +++
 rtl/wb_merge.sv | 125 ++++++++++++
 tb/tb_wb_merge.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_merge_pkg.sv
// Shared definitions for the write-back merge block: load funct3 encodings,
// load FIFO geometry and the FIFO entry layout.
package wb_pkg;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;

    localparam int WB_FIFO_DEPTH = 2;
    localparam int WB_PTR_W      = $clog2(WB_FIFO_DEPTH);
    localparam int WB_CNT_W      = $clog2(WB_FIFO_DEPTH + 1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    function automatic logic is_legal_f3(input logic [2:0] f3);
        return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    endfunction

endpackage

// File: rtl/wb_merge_if.sv
// Bundle of ALU result, load-return and register-file write signals.
// pending_o exists only when WB_PENDING_EN is defined.
interface wb_merge_if;

    logic        alu_valid_i;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;

    logic        ld_valid_i;
    logic        ld_ready_o;
    logic [4:0]  ld_rd_i;
    logic [2:0]  ld_funct3_i;
    logic [1:0]  ld_addr_lo_i;
    logic [31:0] ld_rdata_i;

    logic        RegWrite_o;
    logic [4:0]  RDaddr_o;
    logic [31:0] RDdata_o;
    logic        ld_err_o;
`ifdef WB_PENDING_EN
    logic [31:0] pending_o;
`endif

    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        input  ld_valid_i, ld_rd_i, ld_funct3_i, ld_addr_lo_i, ld_rdata_i,
        output ld_ready_o, RegWrite_o, RDaddr_o, RDdata_o, ld_err_o
`ifdef WB_PENDING_EN
        , output pending_o
`endif
    );

    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i,
        output ld_valid_i, ld_rd_i, ld_funct3_i, ld_addr_lo_i, ld_rdata_i,
        input  ld_ready_o, RegWrite_o, RDaddr_o, RDdata_o, ld_err_o
`ifdef WB_PENDING_EN
        , input  pending_o
`endif
    );

endinterface

// File: rtl/wb_merge_load_align.sv
// Combinational load formatter: selects the byte/half lane, extends it and
// flags illegal funct3 or misaligned accesses.
module load_align
    import wb_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o,
    output logic        err_o
);

    logic [31:0] lane;

    assign lane = rdata_i >> {addr_lo_i, 3'b000};

    always_comb begin
        data_o = '0;
        err_o  = !is_legal_f3(funct3_i);
        case (funct3_i)
            LB:  data_o = {{24{lane[7]}}, lane[7:0]};
            LBU: data_o = {24'b0, lane[7:0]};
            LH: begin
                err_o  = addr_lo_i[0];
                data_o = {{16{lane[15]}}, lane[15:0]};
            end
            LHU: begin
                err_o  = addr_lo_i[0];
                data_o = {16'b0, lane[15:0]};
            end
            LW: begin
                err_o  = (addr_lo_i != 2'd0);
                data_o = rdata_i;
            end
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/wb_merge.sv
// Write-back merge: ALU results take the register-file port first, formatted
// loads wait in a small in-order FIFO. Optional busy bitmap via WB_PENDING_EN.
module wb_merge
    import wb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    wb_merge_if.slave  bus
);

    logic [WB_CNT_W-1:0] count_q, count_d;
    logic [WB_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [WB_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    wb_entry_t           fifo_q [WB_FIFO_DEPTH];
    wb_entry_t           fifo_d [WB_FIFO_DEPTH];

    logic        we_q, we_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    logic        ld_ready;
    logic        accept;
    logic        enq;
    logic        deq;
    logic        alu_sel;
    logic [31:0] ld_fmt;
    logic        ld_bad;

    load_align u_align (
        .funct3_i  (bus.ld_funct3_i),
        .addr_lo_i (bus.ld_addr_lo_i),
        .rdata_i   (bus.ld_rdata_i),
        .data_o    (ld_fmt),
        .err_o     (ld_bad)
    );

    // Ready looks only at the registered count, so a dequeue in the same
    // cycle never reopens a full FIFO.
    assign ld_ready = (count_q < WB_CNT_W'(WB_FIFO_DEPTH));

    always_comb begin
        accept  = bus.ld_valid_i && ld_ready;
        enq     = accept && !ld_bad && (bus.ld_rd_i != 5'd0);
        alu_sel = bus.alu_valid_i && (bus.alu_rd_i != 5'd0);
        deq     = !alu_sel && (count_q != '0);
        err_d   = accept && ld_bad;

        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (enq) begin
            fifo_d[wr_ptr_q] = '{rd: bus.ld_rd_i, data: ld_fmt};
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + WB_CNT_W'(enq) - WB_CNT_W'(deq);

        we_d   = 1'b0;
        rd_d   = rd_q;
        data_d = data_q;
        if (alu_sel) begin
            we_d   = 1'b1;
            rd_d   = bus.alu_rd_i;
            data_d = bus.alu_data_i;
        end else if (deq) begin
            we_d   = 1'b1;
            rd_d   = fifo_q[rd_ptr_q].rd;
            data_d = fifo_q[rd_ptr_q].data;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            we_q     <= 1'b0;
            rd_q     <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            we_q     <= we_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            err_q    <= err_d;
            fifo_q   <= fifo_d;
        end
    end

    assign bus.ld_ready_o = ld_ready;
    assign bus.RegWrite_o = we_q;
    assign bus.RDaddr_o   = rd_q;
    assign bus.RDdata_o   = data_q;
    assign bus.ld_err_o   = err_q;

`ifdef WB_PENDING_EN
    logic [31:0] pending;

    // The output register is left out: the register file forwards the
    // write happening in the same cycle.
    always_comb begin
        logic [WB_PTR_W-1:0] offs;
        pending = '0;
        for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
            offs = WB_PTR_W'(i) - rd_ptr_q;
            if (WB_CNT_W'(offs) < count_q) begin
                pending[fifo_q[i].rd] = 1'b1;
            end
        end
        pending[0] = 1'b0;
    end

    assign bus.pending_o = pending;
`endif

endmodule

// File: tb/tb_wb_merge.sv
// Directed bench for wb_merge with a queue-based scoreboard of expected
// register-file writes.
module tb_wb_merge;
    import wb_pkg::*;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err = 0;
    int   k;
    int   cyc;
    logic last_acc;
    logic [4:0]  last_rd = '0;
    logic [31:0] last_data = '0;
    exp_t mq[$];

    wb_merge_if bus ();

    wb_merge dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic void golden(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w,
                                   output logic [31:0] d, output logic bad);
        logic [31:0] lane;
        lane = w >> (8 * a);
        bad  = 1'b0;
        d    = '0;
        case (f3)
            3'd0: d = {{24{lane[7]}}, lane[7:0]};
            3'd1: if (a[0]) bad = 1'b1; else d = {{16{lane[15]}}, lane[15:0]};
            3'd2: if (a != 2'd0) bad = 1'b1; else d = w;
            3'd4: d = {24'b0, lane[7:0]};
            3'd5: if (a[0]) bad = 1'b1; else d = {16'b0, lane[15:0]};
            default: bad = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] model_pending();
        logic [31:0] p;
        p = '0;
        foreach (mq[i]) p[mq[i].rd] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.alu_valid_i = v;
        bus.alu_rd_i    = rd;
        bus.alu_data_i  = d;
    endtask

    task automatic set_ld(input logic v, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [1:0] a, input logic [31:0] w);
        bus.ld_valid_i   = v;
        bus.ld_rd_i      = rd;
        bus.ld_funct3_i  = f3;
        bus.ld_addr_lo_i = a;
        bus.ld_rdata_i   = w;
    endtask

    // Predict the coming edge from the inputs now applied, step one cycle,
    // then compare the DUT outputs against the prediction.
    task automatic tick();
        logic        exp_ready, acc, exp_we, exp_err, bad;
        logic [31:0] fmt;
        exp_t        e;
        exp_ready = (mq.size() < 2);
        check("ld_ready", 32'(bus.ld_ready_o), 32'(exp_ready));
        acc     = bus.ld_valid_i && exp_ready;
        exp_we  = 1'b0;
        exp_err = 1'b0;
        if (bus.alu_valid_i && bus.alu_rd_i != 5'd0) begin
            exp_we    = 1'b1;
            last_rd   = bus.alu_rd_i;
            last_data = bus.alu_data_i;
        end else if (mq.size() > 0) begin
            e         = mq.pop_front();
            exp_we    = 1'b1;
            last_rd   = e.rd;
            last_data = e.data;
        end
        if (acc) begin
            golden(bus.ld_funct3_i, bus.ld_addr_lo_i, bus.ld_rdata_i, fmt, bad);
            if (bad) exp_err = 1'b1;
            else if (bus.ld_rd_i != 5'd0) mq.push_back('{rd: bus.ld_rd_i, data: fmt});
        end
        last_acc = acc;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check("regwrite", 32'(bus.RegWrite_o), 32'(exp_we));
        check("rdaddr", 32'(bus.RDaddr_o), 32'(last_rd));
        check("rddata", bus.RDdata_o, last_data);
        check("ld_err", 32'(bus.ld_err_o), 32'(exp_err));
`ifdef WB_PENDING_EN
        check("pending", bus.pending_o, model_pending());
`endif
    endtask

    initial begin
        cyc = 0;
        set_alu(1'b0, 5'd0, 32'h0);
        set_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'h0);

        // reset state
        #1;
        check("rst_regwrite", 32'(bus.RegWrite_o), 32'd0);
        check("rst_rdaddr", 32'(bus.RDaddr_o), 32'd0);
        check("rst_rddata", bus.RDdata_o, 32'd0);
        check("rst_ld_err", 32'(bus.ld_err_o), 32'd0);
`ifdef WB_PENDING_EN
        check("rst_pending", bus.pending_o, 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tick();

        // ALU write, latency 1; rd=0 ALU result is ignored
        set_alu(1'b1, 5'd5, 32'h1234);
        tick();
        check("alu_data", bus.RDdata_o, 32'h1234);
        set_alu(1'b1, 5'd0, 32'hDEAD);
        tick();
        set_alu(1'b0, 5'd0, 32'h0);

        // sign and zero extended byte loads, two cycles to the write
        set_ld(1'b1, 5'd3, LB, 2'd1, 32'h0000_8000);
        tick();
        set_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'h0);
        tick();
        check("lb_data", bus.RDdata_o, 32'hFFFF_FF80);
        set_ld(1'b1, 5'd4, LBU, 2'd1, 32'h0000_8000);
        tick();
        set_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'h0);
        tick();
        check("lbu_data", bus.RDdata_o, 32'h0000_0080);

        // back-to-back loads of the remaining legal kinds
        set_ld(1'b1, 5'd12, LH, 2'd2, 32'h8765_4321);  tick();
        set_ld(1'b1, 5'd13, LHU, 2'd2, 32'h8765_4321); tick();
        set_ld(1'b1, 5'd14, LW, 2'd0, 32'hCAFE_F00D);  tick();
        set_ld(1'b1, 5'd15, LB, 2'd3, 32'h7F00_0000);  tick();
        set_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'h0);
        repeat (2) tick();

        // ALU hogs the port: only two loads fit, then they drain in order
        k = 0;
        for (int c = 0; c < 5; c++) begin
            set_alu(1'b1, 5'(20 + c), 32'h100 + 32'(c));
            if (k < 3) set_ld(1'b1, 5'(10 + k), LW, 2'd0, 32'hA000_0000 + 32'(k));
            else set_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'h0);
            tick();
            if (last_acc) k++;
        end
        check("accepted_under_alu", 32'(k), 32'd2);
        check("ready_full", 32'(bus.ld_ready_o), 32'd0);
        set_alu(1'b0, 5'd0, 32'h0);
        for (int c = 0; c < 20 && (k < 3 || mq.size() > 0); c++) begin
            if (k < 3) set_ld(1'b1, 5'(10 + k), LW, 2'd0, 32'hA000_0000 + 32'(k));
            else set_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'h0);
            tick();
            if (last_acc) k++;
        end
        set_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'h0);
        check("drain_done", 32'(mq.size()), 32'd0);
        tick();

        // rejected loads pulse ld_err_o once; rd=0 load is silently dropped
        set_ld(1'b1, 5'd9, LW, 2'd2, 32'h1111_1111);
        tick();
        check("lw_misalign_err", 32'(bus.ld_err_o), 32'd1);
        set_ld(1'b1, 5'd9, 3'd3, 2'd0, 32'h1111_1111); tick();
        set_ld(1'b1, 5'd9, LHU, 2'd1, 32'h1111_1111);  tick();
        set_ld(1'b1, 5'd0, LW, 2'd0, 32'h2222_2222);   tick();
        set_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'h0);
        repeat (2) tick();

        // reset with two loads queued behind an ALU write
        set_alu(1'b1, 5'd6, 32'h66);
        set_ld(1'b1, 5'd21, LW, 2'd0, 32'hAAAA_0001); tick();
        set_ld(1'b1, 5'd22, LW, 2'd0, 32'hAAAA_0002); tick();
        set_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'h0);
        set_alu(1'b1, 5'd8, 32'h88);
        tick();
        set_alu(1'b0, 5'd0, 32'h0);
        rst = 1'b1;
        #1;
        check("midrst_regwrite", 32'(bus.RegWrite_o), 32'd0);
        check("midrst_rdaddr", 32'(bus.RDaddr_o), 32'd0);
        check("midrst_rddata", bus.RDdata_o, 32'd0);
`ifdef WB_PENDING_EN
        check("midrst_pending", bus.pending_o, 32'd0);
`endif
        mq.delete();
        last_rd   = '0;
        last_data = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();

`ifdef WB_PENDING_EN
        set_ld(1'b1, 5'd7, LW, 2'd0, 32'h7777_7777);
        tick();
        set_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'h0);
        check("pending_rd7", bus.pending_o, 32'h0000_0080);
        tick();
        check("pending_clear", bus.pending_o, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
